vtc_pip_ctrl: RTL and testbench

Frame-synchronous controller for the picture-in-picture window offsets of the video timing controller. Accepts window-position requests from a host or control FSM over a valid/ready handshake. Clamps each request so the secondary window stays inside the primary active area, and commits it only at the start of vertical sync so the window never tears mid-frame. Sits beside the timing controller in the pixel clock domain and drives its secondary-window offset inputs.

---
 rtl/vtc_pip_ctrl.sv | 153 +++++++++++++++
 tb/tb_vtc_pip_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vtc_pip_ctrl.sv
// Picture-in-picture offset controller: clamps window-position requests and commits them on the vsync rising edge.
// Optional `PIP_BOUNCE_EN adds an autonomous bounce mode driven by I_bounce_on.
module vtc_pip_ctrl #(
  parameter int H_ActiveSize  = 1024,
  parameter int V_ActiveSize  = 600,
  parameter int H2_ActiveSize = 640,
  parameter int V2_ActiveSize = 480
`ifdef PIP_BOUNCE_EN
  ,
  parameter int STEP          = 2
`endif
) (
  input  logic        I_vtc_clk,
  input  logic        I_vtc_rstn,
  input  logic        I_vtc_vs,
  input  logic        I_req_valid,
  output logic        O_req_ready,
  input  logic [11:0] I_req_x,
  input  logic [11:0] I_req_y,
  output logic [11:0] O_vtc2_offset_x,
  output logic [11:0] O_vtc2_offset_y,
  output logic        O_update_done,
  output logic        O_busy
`ifdef PIP_BOUNCE_EN
  ,
  input  logic        I_bounce_on
`endif
);

  localparam logic [12:0] MAX_X = (H2_ActiveSize >= H_ActiveSize) ? 13'd0 :
                                  13'(H_ActiveSize - H2_ActiveSize);
  localparam logic [12:0] MAX_Y = (V2_ActiveSize >= V_ActiveSize) ? 13'd0 :
                                  13'(V_ActiveSize - V2_ActiveSize);

  typedef enum logic {IDLE, PEND} state_t;

  state_t      state_q, state_d;
  logic        vs_q;
  logic        frame_tick;
  logic [11:0] shadow_x_q, shadow_x_d;
  logic [11:0] shadow_y_q, shadow_y_d;
  logic [11:0] off_x_q, off_x_d;
  logic [11:0] off_y_q, off_y_d;
  logic        done_q, done_d;
  logic        accept;

  function automatic logic [11:0] clamp(input logic [11:0] v, input logic [12:0] lim);
    return ({1'b0, v} > lim) ? lim[11:0] : v;
  endfunction

`ifdef PIP_BOUNCE_EN
  localparam logic [12:0] STEP13 = 13'(STEP);

  logic dir_x_q, dir_x_d;
  logic dir_y_q, dir_y_d;
  logic bounce_active;

  // Returns {new_dir, new_pos}; dir 0 means increasing.
  function automatic logic [12:0] bounce_axis(input logic [11:0] pos, input logic dir,
                                              input logic [12:0] lim);
    logic [12:0] sum;
    logic [12:0] diff;
    sum  = {1'b0, pos} + STEP13;
    diff = {1'b0, pos} - STEP13;
    if (!dir) begin
      if (sum >= lim) return {1'b1, lim[11:0]};
      else            return {1'b0, sum[11:0]};
    end else begin
      if ({1'b0, pos} <= STEP13) return {1'b0, 12'd0};
      else                       return {1'b1, diff[11:0]};
    end
  endfunction

  assign bounce_active = I_bounce_on && (state_q == IDLE);
  assign O_req_ready   = (state_q == IDLE) && !I_bounce_on;
`else
  assign O_req_ready   = (state_q == IDLE);
`endif

  assign frame_tick      = I_vtc_vs & ~vs_q;
  assign accept          = I_req_valid & O_req_ready;
  assign O_busy          = (state_q == PEND);
  assign O_vtc2_offset_x = off_x_q;
  assign O_vtc2_offset_y = off_y_q;
  assign O_update_done   = done_q;

  // A commit only happens from PEND, so a request accepted on a tick waits for the next one.
  always_comb begin
    state_d    = state_q;
    shadow_x_d = shadow_x_q;
    shadow_y_d = shadow_y_q;
    off_x_d    = off_x_q;
    off_y_d    = off_y_q;
    done_d     = 1'b0;
`ifdef PIP_BOUNCE_EN
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          shadow_x_d = clamp(I_req_x, MAX_X);
          shadow_y_d = clamp(I_req_y, MAX_Y);
          state_d    = PEND;
        end
`ifdef PIP_BOUNCE_EN
        if (bounce_active && frame_tick) begin
          {dir_x_d, off_x_d} = bounce_axis(off_x_q, dir_x_q, MAX_X);
          {dir_y_d, off_y_d} = bounce_axis(off_y_q, dir_y_q, MAX_Y);
        end
`endif
      end
      PEND: begin
        if (frame_tick) begin
          off_x_d = shadow_x_q;
          off_y_d = shadow_y_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_vtc_clk or negedge I_vtc_rstn) begin
    if (!I_vtc_rstn) begin
      state_q    <= IDLE;
      vs_q       <= 1'b0;
      shadow_x_q <= 12'd0;
      shadow_y_q <= 12'd0;
      off_x_q    <= 12'd0;
      off_y_q    <= 12'd0;
      done_q     <= 1'b0;
`ifdef PIP_BOUNCE_EN
      dir_x_q    <= 1'b0;
      dir_y_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      vs_q       <= I_vtc_vs;
      shadow_x_q <= shadow_x_d;
      shadow_y_q <= shadow_y_d;
      off_x_q    <= off_x_d;
      off_y_q    <= off_y_d;
      done_q     <= done_d;
`ifdef PIP_BOUNCE_EN
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
`endif
    end
  end

endmodule

// File: tb/tb_vtc_pip_ctrl.sv
// Self-checking bench for vtc_pip_ctrl: table-driven vectors plus hand sequences for reset and vsync corner cases.
module tb_vtc_pip_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        vs;
  logic        valid;
  logic [11:0] req_x;
  logic [11:0] req_y;
  logic        ready;
  logic [11:0] off_x;
  logic [11:0] off_y;
  logic        done;
  logic        busy;
`ifdef PIP_BOUNCE_EN
  logic        bounce_on;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        vs;
    logic        valid;
    logic [11:0] x;
    logic [11:0] y;
    logic        e_ready;
    logic        e_busy;
    logic        e_done;
    logic [11:0] e_x;
    logic [11:0] e_y;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  vtc_pip_ctrl dut (
    .I_vtc_clk      (clk),
    .I_vtc_rstn     (rstn),
    .I_vtc_vs       (vs),
    .I_req_valid    (valid),
    .O_req_ready    (ready),
    .I_req_x        (req_x),
    .I_req_y        (req_y),
    .O_vtc2_offset_x(off_x),
    .O_vtc2_offset_y(off_y),
    .O_update_done  (done),
    .O_busy         (busy)
`ifdef PIP_BOUNCE_EN
    ,
    .I_bounce_on    (bounce_on)
`endif
  );

  task automatic add(input logic v, input logic va, input int x, input int y,
                     input logic r, input logic b, input logic d, input int ex, input int ey);
    vec_t t;
    t.vs = v; t.valid = va; t.x = 12'(x); t.y = 12'(y);
    t.e_ready = r; t.e_busy = b; t.e_done = d; t.e_x = 12'(ex); t.e_y = 12'(ey);
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic r, input logic b, input logic d,
                       input logic [11:0] ex, input logic [11:0] ey);
    checks++;
    if (ready !== r || busy !== b || done !== d || off_x !== ex || off_y !== ey) begin
      errors++;
      $display("FAIL %s: got ready=%0b busy=%0b done=%0b x=%0d y=%0d, expected ready=%0b busy=%0b done=%0b x=%0d y=%0d",
               name, ready, busy, done, off_x, off_y, r, b, d, ex, ey);
    end
  endtask

  // Called at a negedge: drives inputs, advances one clock, returns at the next negedge.
  task automatic step(input logic v, input logic va, input logic [11:0] x, input logic [11:0] y);
    vs = v; valid = va; req_x = x; req_y = y;
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; vs = 1'b0; valid = 1'b0; req_x = 12'd0; req_y = 12'd0;
`ifdef PIP_BOUNCE_EN
    bounce_on = 1'b0;
`endif

    // single vs pulse with nothing pending
    add(1,0,0,0,       1,0,0,0,0);
    add(1,0,0,0,       1,0,0,0,0);
    add(0,0,0,0,       1,0,0,0,0);
    // basic request, extra valid while busy is ignored
    add(0,1,100,50,    0,1,0,0,0);
    add(0,0,0,0,       0,1,0,0,0);
    add(0,1,7,7,       0,1,0,0,0);
    add(1,0,0,0,       1,0,1,100,50);
    add(1,0,0,0,       1,0,0,100,50);
    add(0,0,0,0,       1,0,0,100,50);
    // clamp to limits
    add(0,1,1000,4095, 0,1,0,100,50);
    add(1,0,0,0,       1,0,1,384,120);
    add(0,0,0,0,       1,0,0,384,120);
    // accept on the same cycle as the vs rise
    add(1,1,10,10,     0,1,0,384,120);
    add(1,0,0,0,       0,1,0,384,120);
    add(0,0,0,0,       0,1,0,384,120);
    add(1,0,0,0,       1,0,1,10,10);
    add(0,0,0,0,       1,0,0,10,10);
    // exact limit and one past it
    add(0,1,384,121,   0,1,0,10,10);
    add(1,0,0,0,       1,0,1,384,120);
    add(0,0,0,0,       1,0,0,384,120);
    add(0,1,383,119,   0,1,0,384,120);
    add(1,0,0,0,       1,0,1,383,119);
    add(0,0,0,0,       1,0,0,383,119);

    #12;
    check("reset_state", 1'b1, 1'b0, 1'b0, 12'd0, 12'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].vs, vecs[i].valid, vecs[i].x, vecs[i].y);
      check($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_busy, vecs[i].e_done,
            vecs[i].e_x, vecs[i].e_y);
    end

    // reset while a request is pending
    step(1'b0, 1'b1, 12'd200, 12'd60);
    check("rst_pend_busy", 1'b0, 1'b1, 1'b0, 12'd383, 12'd119);
    valid = 1'b0;
    #2 rstn = 1'b0;
    #1 check("rst_async", 1'b1, 1'b0, 1'b0, 12'd0, 12'd0);
    @(negedge clk);
    rstn = 1'b1;
    step(1'b1, 1'b0, 12'd0, 12'd0);
    check("rst_vs_nocommit", 1'b1, 1'b0, 1'b0, 12'd0, 12'd0);
    step(1'b0, 1'b0, 12'd0, 12'd0);
    check("rst_after", 1'b1, 1'b0, 1'b0, 12'd0, 12'd0);

    // vs held high: a request accepted mid-pulse waits for a fresh rising edge
    step(1'b1, 1'b0, 12'd0, 12'd0);
    step(1'b1, 1'b1, 12'd20, 12'd30);
    check("hold_accept", 1'b0, 1'b1, 1'b0, 12'd0, 12'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 12'd0, 12'd0);
      check($sformatf("hold_high%0d", i), 1'b0, 1'b1, 1'b0, 12'd0, 12'd0);
    end
    step(1'b0, 1'b0, 12'd0, 12'd0);
    step(1'b1, 1'b0, 12'd0, 12'd0);
    check("hold_commit", 1'b1, 1'b0, 1'b1, 12'd20, 12'd30);
    step(1'b1, 1'b0, 12'd0, 12'd0);
    check("hold_single", 1'b1, 1'b0, 1'b0, 12'd20, 12'd30);
    step(1'b0, 1'b0, 12'd0, 12'd0);

`ifdef PIP_BOUNCE_EN
    begin
      logic [11:0] bx[3];
      logic [11:0] by[3];
      bx[0] = 12'd382; bx[1] = 12'd384; bx[2] = 12'd382;
      by[0] = 12'd120; by[1] = 12'd118; by[2] = 12'd116;
      step(1'b0, 1'b1, 12'd380, 12'd118);
      step(1'b1, 1'b0, 12'd0, 12'd0);
      check("bounce_seed", 1'b1, 1'b0, 1'b1, 12'd380, 12'd118);
      step(1'b0, 1'b0, 12'd0, 12'd0);
      bounce_on = 1'b1;
      step(1'b0, 1'b1, 12'd5, 12'd5);
      check("bounce_start", 1'b0, 1'b0, 1'b0, 12'd380, 12'd118);
      for (int f = 0; f < 3; f++) begin
        step(1'b1, 1'b0, 12'd0, 12'd0);
        check($sformatf("bounce_f%0d", f), 1'b0, 1'b0, 1'b0, bx[f], by[f]);
        step(1'b0, 1'b0, 12'd0, 12'd0);
      end
      bounce_on = 1'b0;
      step(1'b0, 1'b0, 12'd0, 12'd0);
      check("bounce_off", 1'b1, 1'b0, 1'b0, 12'd382, 12'd116);
      step(1'b1, 1'b0, 12'd0, 12'd0);
      check("bounce_frozen", 1'b1, 1'b0, 1'b0, 12'd382, 12'd116);
      step(1'b0, 1'b0, 12'd0, 12'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
